decode_pipe: RTL and testbench

- Decode/write-back stage of the five-stage Y86-64 pipeline; sits directly downstream of the fetch stage.
- Consumes the D pipeline register bundle. Decodes source and destination register IDs.
- Reads the 15-entry register file and resolves data hazards by forwarding from the E, M and W stages.
- Loads the E pipeline registers. Also performs the write-back port writes into the register file.

---
 rtl/decode_pipe.sv | 170 +++++++++++++++++
 tb/tb_decode_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// Y86-64 decode/write-back stage: register ID decode, register file with
// E/M/W forwarding, and the E pipeline register bank.
module decode_pipe #(
    parameter int          DATA_W = 64,
    parameter logic [3:0]  RNONE  = 4'hF,
    parameter logic [3:0]  RSP    = 4'h4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E_bubble,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [3:0]        D_stat,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [3:0]        E_stat,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB
);

    logic [DATA_W-1:0] regs_q [0:14];

    logic [3:0]        src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;

    logic [3:0]        ex_icode_q, ex_icode_d, ex_ifun_q, ex_ifun_d, ex_stat_q, ex_stat_d;
    logic [DATA_W-1:0] ex_valc_q, ex_valc_d, ex_vala_q, ex_vala_d, ex_valb_q, ex_valb_d;
    logic [3:0]        ex_dste_q, ex_dste_d, ex_dstm_q, ex_dstm_d;
    logic [3:0]        ex_srca_q, ex_srca_d, ex_srcb_q, ex_srcb_d;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = D_rA;
            4'h9, 4'hB:             src_a = RSP;
            default:                src_a = RNONE;
        endcase
        case (D_icode)
            4'h4, 4'h5, 4'h6:       src_b = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
            default:                src_b = RNONE;
        endcase
        case (D_icode)
            4'h2, 4'h3, 4'h6:       dst_e = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
            default:                dst_e = RNONE;
        endcase
        case (D_icode)
            4'h5, 4'hB:             dst_m = D_rA;
            default:                dst_m = RNONE;
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    // ID F has no storage; the RNONE step of the select chain masks this read anyway.
    assign rf_a = (src_a == RNONE) ? '0 : regs_q[src_a];
    assign rf_b = (src_b == RNONE) ? '0 : regs_q[src_b];

    always_comb begin
        val_a = rf_a;
        if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
        else if (src_a == RNONE)                val_a = '0;
        else if (src_a == e_dstE)               val_a = e_valE;
        else if (src_a == M_dstM)               val_a = m_valM;
        else if (src_a == M_dstE)               val_a = M_valE;
        else if (src_a == W_dstM)               val_a = W_valM;
        else if (src_a == W_dstE)               val_a = W_valE;

        val_b = rf_b;
        if (src_b == RNONE)                     val_b = '0;
        else if (src_b == e_dstE)               val_b = e_valE;
        else if (src_b == M_dstM)               val_b = m_valM;
        else if (src_b == M_dstE)               val_b = M_valE;
        else if (src_b == W_dstM)               val_b = W_valM;
        else if (src_b == W_dstE)               val_b = W_valE;
    end

    always_comb begin
        ex_icode_d = D_icode;
        ex_ifun_d  = D_ifun;
        ex_stat_d  = D_stat;
        ex_valc_d  = D_valC;
        ex_vala_d  = val_a;
        ex_valb_d  = val_b;
        ex_dste_d  = dst_e;
        ex_dstm_d  = dst_m;
        ex_srca_d  = src_a;
        ex_srcb_d  = src_b;
        if (E_bubble) begin
            ex_icode_d = 4'h1;
            ex_ifun_d  = 4'h0;
            ex_stat_d  = 4'h1;
            ex_valc_d  = '0;
            ex_vala_d  = '0;
            ex_valb_d  = '0;
            ex_dste_d  = RNONE;
            ex_dstm_d  = RNONE;
            ex_srca_d  = RNONE;
            ex_srcb_d  = RNONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_icode_q <= 4'h1;
            ex_ifun_q  <= 4'h0;
            ex_stat_q  <= 4'h1;
            ex_valc_q  <= '0;
            ex_vala_q  <= '0;
            ex_valb_q  <= '0;
            ex_dste_q  <= RNONE;
            ex_dstm_q  <= RNONE;
            ex_srca_q  <= RNONE;
            ex_srcb_q  <= RNONE;
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
        end else begin
            ex_icode_q <= ex_icode_d;
            ex_ifun_q  <= ex_ifun_d;
            ex_stat_q  <= ex_stat_d;
            ex_valc_q  <= ex_valc_d;
            ex_vala_q  <= ex_vala_d;
            ex_valb_q  <= ex_valb_d;
            ex_dste_q  <= ex_dste_d;
            ex_dstm_q  <= ex_dstm_d;
            ex_srca_q  <= ex_srca_d;
            ex_srcb_q  <= ex_srcb_d;
            // M port written last so it wins when both target the same register.
            if (W_dstE != RNONE) regs_q[W_dstE] <= W_valE;
            if (W_dstM != RNONE) regs_q[W_dstM] <= W_valM;
        end
    end

    assign E_icode = ex_icode_q;
    assign E_ifun  = ex_ifun_q;
    assign E_stat  = ex_stat_q;
    assign E_valC  = ex_valc_q;
    assign E_valA  = ex_vala_q;
    assign E_valB  = ex_valb_q;
    assign E_dstE  = ex_dste_q;
    assign E_dstM  = ex_dstm_q;
    assign E_srcA  = ex_srca_q;
    assign E_srcB  = ex_srcb_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_decode_pipe;

    localparam int DW = 64;
    localparam logic [3:0] NONE = 4'hF;

    logic          clk = 1'b0;
    logic          rst, E_bubble;
    logic [3:0]    D_icode, D_ifun, D_rA, D_rB, D_stat;
    logic [DW-1:0] D_valC, D_valP;
    logic [3:0]    e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [DW-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]    d_srcA, d_srcB, E_icode, E_ifun, E_stat;
    logic [DW-1:0] E_valC, E_valA, E_valB;
    logic [3:0]    E_dstE, E_dstM, E_srcA, E_srcB;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_pipe #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .E_bubble(E_bubble),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mregs [16];
    bit            model_valid = 0;
    logic [3:0]    x_icode, x_ifun, x_stat, x_dstE, x_dstM, x_srcA, x_srcB;
    logic [DW-1:0] x_valC, x_valA, x_valB;

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return NONE;
    endfunction
    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return NONE;
    endfunction
    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return NONE;
    endfunction
    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return NONE;
    endfunction

    // Youngest producer first; fall back to architectural state.
    function automatic logic [DW-1:0] m_read(input logic [3:0] id);
        logic [3:0]    ids  [5];
        logic [DW-1:0] vals [5];
        if (id == NONE) return '0;
        ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        for (int k = 0; k < 5; k++)
            if (ids[k] == id) return vals[k];
        return mregs[id];
    endfunction

    task automatic m_bubble();
        x_icode = 4'h1; x_ifun = 4'h0; x_stat = 4'h1;
        x_valC = '0; x_valA = '0; x_valB = '0;
        x_dstE = NONE; x_dstM = NONE; x_srcA = NONE; x_srcB = NONE;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_bubble();
            for (int r = 0; r < 16; r++) mregs[r] = '0;
        end else begin
            if (E_bubble) m_bubble();
            else begin
                x_icode = D_icode; x_ifun = D_ifun; x_stat = D_stat; x_valC = D_valC;
                x_srcA  = m_srcA(D_icode, D_rA);
                x_srcB  = m_srcB(D_icode, D_rB);
                x_dstE  = m_dstE(D_icode, D_rB);
                x_dstM  = m_dstM(D_icode, D_rA);
                x_valA  = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_read(x_srcA);
                x_valB  = m_read(x_srcB);
            end
            if (W_dstE != NONE) mregs[W_dstE] = W_valE;
            if (W_dstM != NONE) mregs[W_dstM] = W_valM;
        end
        model_valid = 1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("d_srcA", DW'(d_srcA), DW'(m_srcA(D_icode, D_rA)));
            chk("d_srcB", DW'(d_srcB), DW'(m_srcB(D_icode, D_rB)));
            chk("E_icode", DW'(E_icode), DW'(x_icode));
            chk("E_ifun", DW'(E_ifun), DW'(x_ifun));
            chk("E_stat", DW'(E_stat), DW'(x_stat));
            chk("E_valC", E_valC, x_valC);
            chk("E_valA", E_valA, x_valA);
            chk("E_valB", E_valB, x_valB);
            chk("E_dstE", DW'(E_dstE), DW'(x_dstE));
            chk("E_dstM", DW'(E_dstM), DW'(x_dstM));
            chk("E_srcA", DW'(E_srcA), DW'(x_srcA));
            chk("E_srcB", DW'(E_srcB), DW'(x_srcB));
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr_fwd();
        e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        D_icode = ic; D_ifun = 4'h0; D_rA = ra; D_rB = rb; D_stat = 4'h1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_id();
        if ($urandom_range(0, 2) == 0) return NONE;
        return 4'($urandom_range(0, 5));
    endfunction

    initial begin
        rst = 1'b1; E_bubble = 1'b0;
        set_d(4'h1, NONE, NONE);
        D_valC = '0; D_valP = '0;
        clr_fwd();
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
        step();
        rst = 1'b0;
        chk("rst E_icode", DW'(E_icode), 64'h1);
        chk("rst E_stat", DW'(E_stat), 64'h1);
        chk("rst E_dstE", DW'(E_dstE), 64'hF);
        chk("rst E_valA", E_valA, 64'h0);
        chk("rst E_valB", E_valB, 64'h0);
        chk("rst E_valC", E_valC, 64'h0);

        set_d(4'h2, 4'h0, 4'h3);
        step();
        chk("rrmovq valA", E_valA, 64'h0);

        set_d(4'h1, NONE, NONE);
        W_dstE = 4'h3; W_valE = 64'h55;
        step();
        clr_fwd();
        set_d(4'h6, 4'h3, 4'h3);
        step();
        chk("wb valA", E_valA, 64'h55);
        chk("wb valB", E_valB, 64'h55);

        set_d(4'h2, 4'h2, 4'h0);
        e_dstE = 4'h2; e_valE = 64'hA;
        M_dstE = 4'h2; M_valE = 64'hB;
        W_dstM = 4'h2; W_valM = 64'hC;
        step();
        chk("fwd e", E_valA, 64'hA);
        e_dstE = NONE;
        step();
        chk("fwd M", E_valA, 64'hB);
        M_dstE = NONE;
        step();
        chk("fwd W", E_valA, 64'hC);

        clr_fwd();
        set_d(4'h8, 4'h0, 4'h0);
        D_valP = 64'h123;
        e_dstE = 4'h4; e_valE = 64'h999;
        step();
        chk("call valA", E_valA, 64'h123);
        chk("call srcB", DW'(E_srcB), 64'h4);
        chk("call valB", E_valB, 64'h999);
        chk("call dstE", DW'(E_dstE), 64'h4);

        clr_fwd();
        set_d(4'h5, 4'h1, 4'h4);
        W_dstE = 4'h4; W_valE = 64'h100;
        W_dstM = 4'h4; W_valM = 64'h200;
        step();
        chk("popq fwd valB", E_valB, 64'h200);
        clr_fwd();
        set_d(4'h6, 4'h4, 4'h4);
        step();
        chk("popq reg4", E_valA, 64'h200);

        E_bubble = 1'b1;
        set_d(4'h6, 4'h2, 4'h2);
        W_dstE = 4'h1; W_valE = 64'h7;
        step();
        chk("bubble icode", DW'(E_icode), 64'h1);
        chk("bubble dstE", DW'(E_dstE), 64'hF);
        E_bubble = 1'b0;
        clr_fwd();
        set_d(4'h6, 4'h1, 4'h1);
        step();
        chk("bubble wb", E_valA, 64'h7);

        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            E_bubble = ($urandom_range(0, 9) == 0);
            D_icode  = 4'($urandom_range(0, 15));
            D_ifun   = 4'($urandom_range(0, 15));
            D_rA     = rand_id();
            D_rB     = rand_id();
            D_stat   = 4'($urandom_range(1, 4));
            D_valC   = {$urandom, $urandom};
            D_valP   = {$urandom, $urandom};
            e_dstE   = rand_id();  e_valE = {$urandom, $urandom};
            M_dstE   = rand_id();  M_valE = {$urandom, $urandom};
            M_dstM   = rand_id();  m_valM = {$urandom, $urandom};
            W_dstE   = rand_id();  W_valE = {$urandom, $urandom};
            W_dstM   = rand_id();  W_valM = {$urandom, $urandom};
            step();
        end

        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
